decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: single-entry registered decode stage with a load-use interlock and flush.
module decode_stage #(
    parameter int XLEN   = 16,
    parameter int SEXT   = 1,
    parameter int HAZARD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_op,
    output logic [2:0]      ra_add,
    output logic [2:0]      rb_add,
    output logic [2:0]      wr_add,
    output logic            w_en,
    output logic            bra_c,
    output logic            jump,
    output logic            mem_en,
    output logic            load_store,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_NDU = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_SW  = 4'h5;
    localparam logic [3:0] OP_JAL = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'hC;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic [2:0]      ra;
        logic [2:0]      rb;
        logic [2:0]      wr;
        logic            w_en;
        logic            bra_c;
        logic            jump;
        logic            mem_en;
        logic            load_store;
        logic            illegal;
        logic [XLEN-1:0] imm;
    } bundle_t;

    bundle_t         q, d;
    logic [3:0]      op;
    logic [2:0]      fa, fb, fc;
    logic [XLEN-1:0] imm6_x, imm9_x;
    logic            reads_a, reads_b, hazard;

    assign op     = inst[15:12];
    assign fa     = inst[11:9];
    assign fb     = inst[8:6];
    assign fc     = inst[5:3];
    assign imm6_x = {{(XLEN-6){SEXT != 0 && inst[5]}}, inst[5:0]};
    assign imm9_x = {{(XLEN-9){SEXT != 0 && inst[8]}}, inst[8:0]};

    // LW only reads its base register B; JAL and illegal opcodes read nothing
    assign reads_b  = op inside {OP_ADD, OP_NDU, OP_SW, OP_BEQ, OP_LW};
    assign reads_a  = reads_b && op != OP_LW;
    assign hazard   = HAZARD != 0 && out_valid && q.mem_en && q.load_store &&
                      ((reads_a && fa == q.wr) || (reads_b && fb == q.wr));
    assign in_ready = !rst && (!out_valid || out_ready) && !hazard && !flush;

    always_comb begin
        d = '0;
        case (op)
            OP_ADD, OP_NDU: begin
                d.alu_op = op == OP_NDU ? 3'b001 : 3'b000;
                d.ra     = fa;
                d.rb     = fb;
                d.wr     = fc;
                d.w_en   = 1'b1;
            end
            OP_LW: begin
                d.alu_op     = 3'b111;
                d.rb         = fb;
                d.wr         = fa;
                d.w_en       = 1'b1;
                d.mem_en     = 1'b1;
                d.load_store = 1'b1;
                d.imm        = imm6_x;
            end
            OP_SW: begin
                d.alu_op = 3'b111;
                d.ra     = fa;
                d.rb     = fb;
                d.mem_en = 1'b1;
                d.imm    = imm6_x;
            end
            OP_BEQ: begin
                d.alu_op = 3'b010;
                d.ra     = fa;
                d.rb     = fb;
                d.bra_c  = 1'b1;
                d.imm    = imm6_x;
            end
            OP_JAL: begin
                d.wr   = fa;
                d.w_en = 1'b1;
                d.jump = 1'b1;
                d.imm  = imm9_x;
            end
            default: d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_op     = q.alu_op;
    assign ra_add     = q.ra;
    assign rb_add     = q.rb;
    assign wr_add     = q.wr;
    assign w_en       = q.w_en;
    assign bra_c      = q.bra_c;
    assign jump       = q.jump;
    assign mem_en     = q.mem_en;
    assign load_store = q.load_store;
    assign illegal    = q.illegal;
    assign imm        = q.imm;
endmodule
